timer_counter: RTL and testbench

//   Memory-mapped countdown timer that is one source of the HwInt vector feeding the

---
 rtl/timer_counter.sv | 207 ++++++++++++++++++++
 tb/tb_timer_counter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//   Memory-mapped countdown timer. It is one source of the CP0 HwInt vector and
//   its IRQ output drives one HwInt bit directly. Software programs it through
//   three word registers:
//     Addr 0 CTRL   : [0] Enable, [2:1] Mode (01 auto-reload, else one-shot),
//                     [3] IM (irq mask); upper bits read as zero
//     Addr 1 PRESET : reload value, WIDTH bits, read/write
//     Addr 2 COUNT  : live counter, read-only
//     Addr 3        : unused, reads zero, writes ignored
//   One-shot mode holds IRQ until software writes CTRL. Auto-reload mode gives
//   a single-cycle IRQ pulse every PRESET+3 cycles.
//
// Ports
//   clk   in   1   system clock, rising edge
//   rst   in   1   asynchronous reset, active low
//   WE    in   1   bus write enable
//   Addr  in   2   register word select
//   Din   in  32   bus write data
//   Dout  out 32   bus read data, combinational from Addr
//   IRQ   out  1   interrupt request, built only from registered state
//
// FSM states
//   state  | meaning
//   IDLE   | timer stopped, waiting for Enable
//   LOAD   | copy PRESET into COUNT
//   CNT    | counting down; reaching zero raises the flag
//   INT    | flag just raised; one-shot stops, auto-reload restarts
// -----------------------------------------------------------------------------
module timer_counter #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic [1:0]  Addr,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_AUTO   = 2'b01;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_enable;
  logic [1:0]       r_mode;
  logic             r_im;
  logic [WIDTH-1:0] r_preset;
  logic [WIDTH-1:0] r_count;
  logic             r_flag;

  logic             w_enable_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_flag_nxt;

  logic             w_ctrl_we;
  logic             w_preset_we;
  logic             w_auto;
  logic [31:0]      w_ctrl_rd;
  logic [31:0]      w_preset_rd;
  logic [31:0]      w_count_rd;

  // ---------------------------------------------------------------------------
  // Bus write decode
  // ---------------------------------------------------------------------------
  assign w_ctrl_we   = WE && (Addr == ADDR_CTRL);
  assign w_preset_we = WE && (Addr == ADDR_PRESET);

  // Mode 1x is treated as one-shot, so only the exact 01 pattern reloads.
  assign w_auto = (r_mode == MODE_AUTO);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state plus next values of COUNT, flag and Enable.
  // Ordering inside this block encodes the same-edge priorities:
  //   - a CTRL write clears the flag, but a CNT->INT flag set overrides it
  //   - the one-shot Enable clear in INT is overridden by a CTRL write
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_flag_nxt   = r_flag;
    w_enable_nxt = r_enable;

    if (w_ctrl_we) begin
      w_flag_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (r_enable) begin
          w_state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = S_CNT;
      end

      S_CNT: begin
        if (!r_enable) begin
          w_state_nxt = S_IDLE;
        end else if (r_count == '0) begin
          w_state_nxt = S_INT;
          w_flag_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count - WIDTH'(1);
        end
      end

      S_INT: begin
        if (w_auto) begin
          w_state_nxt = S_LOAD;
          w_flag_nxt  = 1'b0;
        end else begin
          // flag deliberately left set: one-shot IRQ is a level held until ack
          w_state_nxt  = S_IDLE;
          w_enable_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_ctrl_we) begin
      w_enable_nxt = Din[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers: CTRL fields, PRESET, COUNT, flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_enable <= 1'b0;
      r_mode   <= 2'b00;
      r_im     <= 1'b0;
      r_preset <= '0;
      r_count  <= '0;
      r_flag   <= 1'b0;
    end else begin
      r_enable <= w_enable_nxt;
      r_count  <= w_count_nxt;
      r_flag   <= w_flag_nxt;
      if (w_ctrl_we) begin
        r_mode <= Din[2:1];
        r_im   <= Din[3];
      end
      if (w_preset_we) begin
        r_preset <= Din[WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path, zero-extended to the bus width
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ctrl_rd               = '0;
    w_ctrl_rd[0]            = r_enable;
    w_ctrl_rd[2:1]          = r_mode;
    w_ctrl_rd[3]            = r_im;
    w_preset_rd             = '0;
    w_preset_rd[WIDTH-1:0]  = r_preset;
    w_count_rd              = '0;
    w_count_rd[WIDTH-1:0]   = r_count;
  end

  always_comb begin
    Dout = '0;
    case (Addr)
      ADDR_CTRL:   Dout = w_ctrl_rd;
      ADDR_PRESET: Dout = w_preset_rd;
      ADDR_COUNT:  Dout = w_count_rd;
      default:     Dout = '0;
    endcase
  end

  // Both operands are flops, so IRQ has no combinational path from the bus.
  assign IRQ = r_flag & r_im;

endmodule

// File: tb/tb_timer_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_counter
//   Self-checking bench for timer_counter. A table of single-cycle bus vectors
//   covers one-shot, masking, abort, collision and register-map behaviour; hand
//   sequences cover reset, auto-reload periods, mid-count PRESET change and
//   reset while IRQ is high. Each driven cycle pushes its expected read value
//   and IRQ into a scoreboard queue, popped and compared after the clock edge.
// -----------------------------------------------------------------------------
module tb_timer_counter;

  logic        clk;
  logic        rst;
  logic        WE;
  logic [1:0]  Addr;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  timer_counter #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .WE   (WE),
    .Addr (Addr),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [1:0]  raddr;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  typedef struct {
    logic [1:0]  raddr;
    logic [31:0] dout;
    logic        irq;
    int          tag;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic we, input logic [1:0] addr, input logic [31:0] din,
                              input logic [1:0] raddr, input logic [31:0] exp_dout,
                              input logic exp_irq);
    vec_t v;
    v.we = we; v.addr = addr; v.din = din;
    v.raddr = raddr; v.exp_dout = exp_dout; v.exp_irq = exp_irq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive, push expectation, clock, then read back and compare.
  task automatic step(input logic we, input logic [1:0] addr, input logic [31:0] din,
                      input logic [1:0] raddr, input logic [31:0] exp_dout,
                      input logic exp_irq, input int tag);
    exp_t e;
    WE = we; Addr = addr; Din = din;
    e.raddr = raddr; e.dout = exp_dout; e.irq = exp_irq; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    WE = 1'b0;
    e = sb_q.pop_front();
    Addr = e.raddr;
    #1;
    check($sformatf("dout[%0d] addr%0d", e.tag, e.raddr), Dout, e.dout);
    check($sformatf("irq[%0d]", e.tag), {31'b0, IRQ}, {31'b0, e.irq});
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_irq;

    // ---------------- vector table ----------------
    // one-shot, PRESET=5, CTRL=0x9 at E0: IRQ after E8, Enable cleared at E9
    tbl.push_back(mk(1, 1, 32'd5,  1, 32'd5, 0));
    tbl.push_back(mk(1, 0, 32'h9,  0, 32'h9, 0));   // E0
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd0, 0));   // E1 LOAD
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd5, 0));   // E2
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd4, 0));
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd3, 0));
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd2, 0));
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd1, 0));
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd0, 0));   // E7
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd0, 1));   // E8 IRQ rises
    tbl.push_back(mk(0, 0, 32'h0,  0, 32'h8, 1));   // E9 Enable cleared
    tbl.push_back(mk(0, 0, 32'h0,  0, 32'h8, 1));
    tbl.push_back(mk(1, 0, 32'h8,  0, 32'h8, 0));   // ack
    // masked: PRESET=3, CTRL=0x1; flag sets silently, ack with IM keeps IRQ low
    tbl.push_back(mk(1, 1, 32'd3,  1, 32'd3, 0));
    tbl.push_back(mk(1, 0, 32'h1,  0, 32'h1, 0));   // E0
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd0, 0));   // E1
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd3, 0));
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd2, 0));
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd1, 0));
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd0, 0));
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd0, 0));   // E6 flag set, masked
    tbl.push_back(mk(0, 0, 32'h0,  0, 32'h0, 0));   // E7 Enable cleared
    tbl.push_back(mk(1, 0, 32'h8,  0, 32'h8, 0));   // ack clears flag
    tbl.push_back(mk(0, 0, 32'h0,  0, 32'h8, 0));
    // abort during CNT: count frozen, no IRQ
    tbl.push_back(mk(1, 1, 32'd6,  1, 32'd6, 0));
    tbl.push_back(mk(1, 0, 32'h9,  0, 32'h9, 0));   // E0
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd0, 0));
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd6, 0));
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd5, 0));
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd4, 0));
    tbl.push_back(mk(1, 0, 32'h8,  2, 32'd3, 0));   // disable lands; last decrement
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd3, 0));   // IDLE, frozen
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd3, 0));
    tbl.push_back(mk(0, 0, 32'h0,  0, 32'h8, 0));
    // abort during LOAD: LOAD completes, then IDLE
    tbl.push_back(mk(1, 0, 32'h9,  0, 32'h9, 0));   // E0
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd3, 0));   // E1 LOAD
    tbl.push_back(mk(1, 0, 32'h8,  2, 32'd6, 0));   // E2 load done
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd6, 0));
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd6, 0));
    // collision: CTRL write on CNT->INT edge, then on the INT edge
    tbl.push_back(mk(1, 1, 32'd1,  1, 32'd1, 0));
    tbl.push_back(mk(1, 0, 32'h9,  0, 32'h9, 0));   // E0
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd6, 0));
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd1, 0));
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd0, 0));
    tbl.push_back(mk(1, 0, 32'h9,  0, 32'h9, 1));   // E4 flag set beats ack
    tbl.push_back(mk(1, 0, 32'h9,  0, 32'h9, 0));   // E5 written Enable kept
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd0, 0));   // LOAD again
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd1, 0));
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd0, 0));
    tbl.push_back(mk(0, 0, 32'h0,  0, 32'h9, 1));
    tbl.push_back(mk(1, 0, 32'h8,  0, 32'h8, 0));
    // register map
    tbl.push_back(mk(1, 3, 32'hFFFF_FFFF, 3, 32'h0, 0));
    tbl.push_back(mk(0, 0, 32'h0,  0, 32'h8, 0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 32'd1, 0));
    tbl.push_back(mk(1, 2, 32'h55, 2, 32'd0, 0));
    tbl.push_back(mk(1, 0, 32'hFFFF_FFF8, 0, 32'h8, 0));
    tbl.push_back(mk(1, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0));
    // PRESET=0, Mode=10 (one-shot): IRQ after E3, held
    tbl.push_back(mk(1, 1, 32'd0,  1, 32'd0, 0));
    tbl.push_back(mk(1, 0, 32'hD,  0, 32'hD, 0));   // E0
    tbl.push_back(mk(0, 0, 32'h0,  0, 32'hD, 0));
    tbl.push_back(mk(0, 0, 32'h0,  2, 32'd0, 0));
    tbl.push_back(mk(0, 0, 32'h0,  0, 32'hD, 1));   // E3
    tbl.push_back(mk(0, 0, 32'h0,  0, 32'hC, 1));   // E4 one-shot stop
    tbl.push_back(mk(1, 0, 32'h0,  0, 32'h0, 0));

    // ---------------- reset with random bus traffic ----------------
    rst = 1'b0; WE = 1'b0; Addr = 2'd0; Din = '0;
    for (int i = 0; i < 6; i++) begin
      WE   = 1'($urandom);
      Addr = 2'($urandom);
      Din  = $urandom;
      @(negedge clk);
      for (int a = 0; a < 3; a++) begin
        Addr = 2'(a);
        #1;
        check($sformatf("reset dout addr%0d", a), Dout, 32'h0);
      end
      check("reset irq", {31'b0, IRQ}, 32'h0);
    end
    WE = 1'b0;
    rst = 1'b1;
    step(0, 0, 0, 0, 32'h0, 0, 900);
    step(0, 0, 0, 2, 32'h0, 0, 901);
    step(0, 0, 0, 1, 32'h0, 0, 902);

    foreach (tbl[i]) begin
      step(tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].raddr, tbl[i].exp_dout, tbl[i].exp_irq, i);
    end

    // ---------------- auto-reload, PRESET=2: pulse every 5 cycles ----------------
    step(1, 1, 32'd2, 1, 32'd2, 0, 300);
    step(1, 0, 32'hB, 0, 32'hB, 0, 300);
    for (int k = 1; k <= 26; k++) begin
      exp_irq = (k >= 5) && (((k - 5) % 5) == 0);
      step(0, 0, 0, 0, 32'hB, exp_irq, 300 + k);
    end
    step(1, 0, 32'h0, 2, 32'd2, 0, 330);
    step(0, 0, 32'h0, 2, 32'd2, 0, 331);

    // ---------------- auto-reload, PRESET 3 -> 7 written mid-count ----------------
    step(1, 1, 32'd3, 1, 32'd3, 0, 400);
    step(1, 0, 32'hB, 0, 32'hB, 0, 400);
    for (int k = 1; k <= 33; k++) begin
      exp_irq = (k == 6) || (k == 12) || (k == 22) || (k == 32);
      if (k == 9) step(1, 1, 32'd7, 0, 32'hB, exp_irq, 400 + k);
      else        step(0, 0, 32'd0, 0, 32'hB, exp_irq, 400 + k);
    end
    step(1, 0, 32'h0, 2, 32'd7, 0, 440);
    step(0, 0, 32'h0, 2, 32'd7, 0, 441);

    // ---------------- reset while IRQ is high ----------------
    step(1, 1, 32'd2, 1, 32'd2, 0, 500);
    step(1, 0, 32'h9, 0, 32'h9, 0, 500);
    step(0, 0, 32'h0, 2, 32'd7, 0, 501);
    step(0, 0, 32'h0, 2, 32'd2, 0, 502);
    step(0, 0, 32'h0, 2, 32'd1, 0, 503);
    step(0, 0, 32'h0, 2, 32'd0, 0, 504);
    step(0, 0, 32'h0, 1, 32'd2, 1, 505);
    #1;
    rst = 1'b0;
    #1;
    check("async reset irq", {31'b0, IRQ}, 32'h0);
    for (int a = 0; a < 3; a++) begin
      Addr = 2'(a);
      #1;
      check($sformatf("async reset dout addr%0d", a), Dout, 32'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 0, 0, 32'h0, 0, 510);
    step(0, 0, 0, 2, 32'h0, 0, 511);
    step(0, 0, 0, 1, 32'h0, 0, 512);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
